// File: rtl/bitcount_pkg.sv
// Shared defaults and FSM state type for the round-robin bit-count scheduler.
package bitcount_pkg;

  localparam int unsigned N_REQ_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = $clog2(DATA_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bitcount_datapath.sv
// Operand shift register and population-count accumulator driven by the scheduler FSM.
module bitcount_datapath
  import bitcount_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_a,
  input  logic [DATA_W-1:0] a_in,
  input  logic              clear_result,
  input  logic              right_shift,
  input  logic              incr_result,
  output logic              a_zero,
  output logic              a_lsb,
  output logic [CNT_W-1:0]  result
);

  logic [DATA_W-1:0] a_q;
  logic [CNT_W-1:0]  result_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q      <= '0;
      result_q <= '0;
    end else begin
      if (load_a) begin
        a_q <= a_in;
      end else if (right_shift) begin
        a_q <= a_q >> 1;
      end
      if (clear_result) begin
        result_q <= '0;
      end else if (incr_result) begin
        result_q <= result_q + CNT_W'(1);
      end
    end
  end

  assign a_zero = (a_q == '0);
  assign a_lsb  = a_q[0];
  assign result = result_q;

endmodule

// File: rtl/bitcount_scheduler.sv
// Round-robin arbiter plus FSM sharing one serial bit-count datapath among N_REQ requesters.
module bitcount_scheduler
  import bitcount_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      resp_valid,
  output logic [$clog2(N_REQ)-1:0]  resp_id,
  output logic [CNT_W-1:0]          resp_count
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [DATA_W-1:0] sel_data;
  logic              load_a, clear_result, right_shift, incr_result;
  logic              a_zero, a_lsb;
  logic [CNT_W-1:0]  result;

  logic [N_REQ-1:0]  gnt_q;
  logic              busy_q, resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  logic [CNT_W-1:0]  resp_count_q;

  // Round-robin pick: nearest pending requester above last, wrapping; scanned far-to-near so nearest wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      if (req[(int'(last_q) + k) % int'(N_REQ)]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'((int'(last_q) + k) % int'(N_REQ));
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_id_q == ID_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  bitcount_datapath #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load_a       (load_a),
    .a_in         (sel_data),
    .clear_result (clear_result),
    .right_shift  (right_shift),
    .incr_result  (incr_result),
    .a_zero       (a_zero),
    .a_lsb        (a_lsb),
    .result       (result)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      last_q   <= ID_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    last_d       = last_q;
    load_a       = 1'b0;
    clear_result = 1'b0;
    right_shift  = 1'b0;
    incr_result  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_d = pick_id;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_a       = 1'b1;
        clear_result = 1'b1;
        state_d      = SHIFT;
      end
      SHIFT: begin
        if (a_zero) begin
          state_d = DONE;
        end else begin
          right_shift = 1'b1;
          incr_result = a_lsb;
        end
      end
      DONE: begin
        last_d  = gnt_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_count_q <= '0;
    end else begin
      gnt_q        <= (state_d != IDLE) ? (N_REQ'(1) << gnt_id_d) : '0;
      busy_q       <= (state_d != IDLE);
      resp_valid_q <= (state_d == DONE);
      resp_id_q    <= (state_d == DONE) ? gnt_id_d : '0;
      resp_count_q <= (state_d == DONE) ? result : '0;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_count = resp_count_q;

endmodule

// File: tb/tb_bitcount_scheduler.sv
// Directed, table-driven bench for bitcount_scheduler with hand-computed latencies and counts.
module tb_bitcount_scheduler;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          MAX_EDGES = 40;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    busy;
  logic                    resp_valid;
  logic [1:0]              resp_id;
  logic [CNT_W-1:0]        resp_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          do_reset;
    logic [3:0]  req_v;
    logic [31:0] data_v;
    logic [3:0]  post_req;
    int          exp_id;
    int          exp_cnt;
    int          exp_edges;
  } vec_t;

  vec_t vecs[10];

  bitcount_scheduler #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_count (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_gnt",   int'(gnt), 0);
    chk("reset_busy",  int'(busy), 0);
    chk("reset_valid", int'(resp_valid), 0);
    chk("reset_id",    int'(resp_id), 0);
    chk("reset_count", int'(resp_count), 0);
  endtask

  // Drives one transaction from IDLE and counts edges (IDLE sampling edge = 1) to resp_valid.
  task automatic serve(input int k, input vec_t v);
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    req      = v.req_v;
    req_data = v.data_v;
    while (n < MAX_EDGES && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk($sformatf("v%0d_gnt_load", k), int'(gnt), 1 << v.exp_id);
        chk($sformatf("v%0d_busy_load", k), int'(busy), 1);
        req = v.post_req;
      end
      if (resp_valid) got = 1;
      else if (n > 1) chk($sformatf("v%0d_idle_resp_zero", k),
                          int'({resp_id, resp_count}), 0);
    end
    chk($sformatf("v%0d_latency", k), n, v.exp_edges);
    chk($sformatf("v%0d_resp_id", k), int'(resp_id), v.exp_id);
    chk($sformatf("v%0d_resp_count", k), int'(resp_count), v.exp_cnt);
    chk($sformatf("v%0d_gnt_done", k), int'(gnt), 1 << v.exp_id);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_valid_after", k), int'(resp_valid), 0);
    chk($sformatf("v%0d_resp_zero_after", k), int'({resp_id, resp_count}), 0);
    chk($sformatf("v%0d_busy_after", k), int'(busy), 0);
    chk($sformatf("v%0d_gnt_after", k), int'(gnt), 0);
  endtask

  initial begin
    vec_t v;
    int   saw_valid;

    //          rst  req      data           post     id cnt edges
    vecs[0] = '{1'b1, 4'b0001, 32'h0000_00AA, 4'b0001, 0, 4, 11};
    vecs[1] = '{1'b0, 4'b0100, 32'h0000_0000, 4'b0100, 2, 0, 3};
    vecs[2] = '{1'b1, 4'b1111, 32'hFF07_0301, 4'b1111, 0, 1, 4};
    vecs[3] = '{1'b0, 4'b1111, 32'hFF07_0301, 4'b1111, 1, 2, 5};
    vecs[4] = '{1'b0, 4'b1111, 32'hFF07_0301, 4'b1111, 2, 3, 6};
    vecs[5] = '{1'b0, 4'b1111, 32'hFF07_0301, 4'b1111, 3, 8, 11};
    vecs[6] = '{1'b0, 4'b1111, 32'hFF07_0301, 4'b0000, 0, 1, 4};
    vecs[7] = '{1'b1, 4'b1010, 32'h0F00_3005, 4'b1011, 1, 2, 9};
    vecs[8] = '{1'b0, 4'b1011, 32'h0F00_3005, 4'b1011, 3, 4, 7};
    vecs[9] = '{1'b0, 4'b1011, 32'h0F00_3005, 4'b0000, 0, 2, 6};

    reset    = 1'b0;
    req      = '0;
    req_data = '0;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      if (v.do_reset) apply_reset();
      serve(i, v);
    end

    // Operand 0x80 with request dropped right after grant: response must still appear.
    apply_reset();
    serve(10, '{1'b1, 4'b0001, 32'h0000_0080, 4'b0000, 0, 1, 11});

    // Reset during SHIFT of 0xF0 abandons the operation and restores id-0 priority.
    apply_reset();
    req      = 4'b0001;
    req_data = 32'h0300_00F0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_shift", int'(busy), 1);
    reset = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    chk("abort_busy",  int'(busy), 0);
    chk("abort_gnt",   int'(gnt), 0);
    chk("abort_valid", int'(resp_valid), 0);
    reset = 1'b1;
    saw_valid = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (resp_valid) saw_valid = 1;
    end
    chk("abort_no_resp", saw_valid, 0);
    serve(11, '{1'b0, 4'b1000, 32'h0300_00F0, 4'b0000, 3, 2, 5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
